tx_frame_loader: RTL and testbench

TX_FRAME_LOADER -- requirements
Module: tx_frame_loader

---
 rtl/tx_frame_loader.sv | 103 ++++++++++
 tb/tb_tx_frame_loader.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/tx_frame_loader.sv
// Streams payload bytes into a transmit FIFO, zero-pads short frames, truncates long ones
// and pulses pct_qued with the written length once each frame is complete in the FIFO.
module tx_frame_loader #(
    parameter int MIN_PAYLOAD = 46,
    parameter int MAX_PAYLOAD = 1500
) (
    input  logic        clk,
    input  logic        arst_n,
    input  logic [7:0]  s_data,
    input  logic        s_valid,
    input  logic        s_last,
    output logic        s_ready,
    input  logic        fifo_full,
    output logic        w_en,
    output logic [7:0]  data_out,
    output logic        pct_qued,
    output logic [10:0] frame_len,
    output logic        oversize
);
    localparam logic [10:0] MIN_L = 11'(MIN_PAYLOAD);
    localparam logic [10:0] MAX_L = 11'(MAX_PAYLOAD);

    typedef enum logic [2:0] {IDLE, DATA, PAD, DISCARD, QUEUE} state_t;

    state_t      state;
    logic [10:0] cnt;
    logic [10:0] cnt_inc;
    logic        accept;
    logic        wr_data;
    logic        wr_pad;

    // Write path is combinational; gating with arst_n keeps outputs quiet during reset.
    always_comb begin
        s_ready = 1'b0;
        unique case (state)
            IDLE, DATA: s_ready = !fifo_full;
            DISCARD:    s_ready = 1'b1;
            default:    s_ready = 1'b0;
        endcase
        s_ready  = s_ready & arst_n;
        accept   = s_valid && s_ready;
        wr_data  = accept && (state == IDLE || state == DATA);
        wr_pad   = arst_n && (state == PAD) && !fifo_full;
        w_en     = wr_data || wr_pad;
        data_out = wr_data ? s_data : 8'h00;
        cnt_inc  = (state == IDLE) ? 11'd1 : cnt + 11'd1;
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            pct_qued  <= 1'b0;
            frame_len <= '0;
            oversize  <= 1'b0;
        end else begin
            pct_qued <= 1'b0;
            unique case (state)
                IDLE, DATA: begin
                    if (accept) begin
                        cnt <= cnt_inc;
                        if (state == IDLE)
                            oversize <= 1'b0;
                        if (s_last) begin
                            if (cnt_inc < MIN_L) begin
                                state <= PAD;
                            end else begin
                                state     <= QUEUE;
                                pct_qued  <= 1'b1;
                                frame_len <= cnt_inc;
                            end
                        end else if (cnt_inc == MAX_L) begin
                            state <= DISCARD;
                        end else begin
                            state <= DATA;
                        end
                    end
                end
                PAD: begin
                    if (!fifo_full) begin
                        cnt <= cnt + 11'd1;
                        if (cnt + 11'd1 == MIN_L) begin
                            state     <= QUEUE;
                            pct_qued  <= 1'b1;
                            frame_len <= MIN_L;
                        end
                    end
                end
                DISCARD: begin
                    // Flag is visible by the QUEUE cycle even when the tail is a single byte.
                    oversize <= 1'b1;
                    if (accept && s_last) begin
                        state     <= QUEUE;
                        pct_qued  <= 1'b1;
                        frame_len <= cnt;
                    end
                end
                QUEUE:   state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_tx_frame_loader.sv
// Scoreboard bench: drivers push expected writes/frames, a negedge monitor pops and compares.
module tb_tx_frame_loader;
    localparam int MIN = 46;
    localparam int MAX = 1500;

    typedef struct {
        logic [10:0] len;
        logic        ovs;
    } frm_t;

    logic        clk = 1'b0;
    logic        arst_n = 1'b0;
    logic [7:0]  s_data = 8'h00;
    logic        s_valid = 1'b0;
    logic        s_last = 1'b0;
    logic        fifo_full = 1'b0;
    logic        s_ready;
    logic        w_en;
    logic [7:0]  data_out;
    logic        pct_qued;
    logic [10:0] frame_len;
    logic        oversize;

    logic [7:0]  exp_q[$];
    frm_t        frm_q[$];
    int          n_chk = 0;
    int          n_fail = 0;
    int          n_writes = 0;
    int          n_pulses = 0;
    bit          rand_full = 1'b0;
    logic [10:0] prev_len = '0;

    tx_frame_loader #(.MIN_PAYLOAD(MIN), .MAX_PAYLOAD(MAX)) dut (
        .clk(clk), .arst_n(arst_n), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
        .s_ready(s_ready), .fifo_full(fifo_full), .w_en(w_en), .data_out(data_out),
        .pct_qued(pct_qued), .frame_len(frame_len), .oversize(oversize)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_chk++;
        n_fail++;
        $display("FAIL %s: unexpected event at %0t", name, $time);
    endtask

    // Monitor
    always @(negedge clk) begin
        if (arst_n) begin
            if (w_en) begin
                n_writes++;
                check("w_en_while_full", {31'd0, fifo_full}, 32'd0);
                if (exp_q.size() == 0) fail_now("unexpected_write");
                else check("write_data", {24'd0, data_out}, {24'd0, exp_q.pop_front()});
            end else begin
                check("idle_data", {24'd0, data_out}, 32'd0);
            end
            if (fifo_full) check("ready_while_full", {31'd0, s_ready}, 32'd0);
            if (pct_qued) begin
                n_pulses++;
                check("queue_ready", {31'd0, s_ready}, 32'd0);
                if (frm_q.size() == 0) begin
                    fail_now("unexpected_pct_qued");
                end else begin
                    frm_t f;
                    f = frm_q.pop_front();
                    check("frame_len", {21'd0, frame_len}, {21'd0, f.len});
                    check("oversize", {31'd0, oversize}, {31'd0, f.ovs});
                end
            end else if (frame_len !== prev_len) begin
                fail_now("frame_len_unstable");
            end
        end
        prev_len = frame_len;
    end

    // FIFO back-pressure generator
    initial forever begin
        @(posedge clk);
        #1;
        fifo_full = rand_full ? 1'($urandom_range(0, 1)) : 1'b0;
    end

    task automatic wait_accept();
        int t = 0;
        forever begin
            @(negedge clk);
            if (s_ready) break;
            t++;
            if (t > 200) begin
                $display("FAIL accept_timeout: s_ready never rose at %0t", $time);
                $fatal(1);
            end
        end
        @(posedge clk);
        #1;
    endtask

    // Sends n bytes; when done is 0 the frame is left unterminated.
    task automatic send_frame(input int n, input int seed, input bit hold, input bit done);
        for (int i = 0; i < n; i++) begin
            s_valid = 1'b1;
            s_data  = 8'(i * 7 + seed);
            s_last  = done && (i == n - 1);
            if (i < MAX) exp_q.push_back(s_data);
            wait_accept();
        end
        if (done) begin
            frm_t f;
            for (int i = n; i < MIN; i++) exp_q.push_back(8'h00);
            f.len = (n < MIN) ? 11'(MIN) : (n > MAX) ? 11'(MAX) : 11'(n);
            f.ovs = (n > MAX);
            frm_q.push_back(f);
        end
        s_last = 1'b0;
        if (!hold) s_valid = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while ((exp_q.size() != 0 || frm_q.size() != 0) && t < 3000) begin
            @(posedge clk);
            t++;
        end
        check("drain_timeout", {31'd0, (t >= 3000)}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        #3;
        check("rst_w_en", {31'd0, w_en}, 32'd0);
        check("rst_s_ready", {31'd0, s_ready}, 32'd0);
        check("rst_frame_len", {21'd0, frame_len}, 32'd0);
        check("rst_pct_qued", {31'd0, pct_qued}, 32'd0);
        #10 arst_n = 1'b1;
        @(posedge clk);
        #1;

        // 60-byte frame, no back-pressure
        send_frame(60, 1, 1'b0, 1'b1);
        drain();

        // 10-byte frame: 36 pad writes, s_ready low through PAD and QUEUE
        send_frame(10, 3, 1'b0, 1'b1);
        for (int k = 0; k < 37; k++) begin
            @(negedge clk);
            check("pad_ready", {31'd0, s_ready}, 32'd0);
        end
        drain();

        // 1600-byte frame truncated at MAX
        send_frame(1600, 5, 1'b0, 1'b1);
        drain();

        // random back-pressure through DATA and PAD
        rand_full = 1'b1;
        send_frame(30, 9, 1'b0, 1'b1);
        drain();
        rand_full = 1'b0;
        @(posedge clk);
        #1;

        // reset mid-frame after 20 bytes
        send_frame(20, 11, 1'b0, 1'b0);
        s_valid = 1'b1;
        s_data  = 8'hAA;
        #2 arst_n = 1'b0;
        #1;
        check("mid_rst_w_en", {31'd0, w_en}, 32'd0);
        check("mid_rst_s_ready", {31'd0, s_ready}, 32'd0);
        check("mid_rst_data", {24'd0, data_out}, 32'd0);
        check("mid_rst_pct_qued", {31'd0, pct_qued}, 32'd0);
        check("mid_rst_frame_len", {21'd0, frame_len}, 32'd0);
        check("mid_rst_oversize", {31'd0, oversize}, 32'd0);
        s_valid = 1'b0;
        @(negedge clk);
        #2 arst_n = 1'b1;
        @(posedge clk);
        #1;
        send_frame(50, 13, 1'b0, 1'b1);
        drain();

        // back-to-back frames with s_valid held high
        send_frame(46, 17, 1'b1, 1'b1);
        send_frame(1500, 19, 1'b0, 1'b1);
        drain();

        check("exp_q_empty", exp_q.size(), 32'd0);
        check("pulse_count", n_pulses, 32'd7);
        check("write_count", n_writes, 32'd3268);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1);
    end
endmodule
